// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between the APB-to-SPI master and the register-file slave.
// All four pins are plain single-bit wires; MISO is never tristated.
interface spi_slave_regfile_if;
    logic SCLK;
    logic SS;
    logic MOSI;
    logic MISO;

    modport master (output SCLK, output SS, output MOSI, input MISO);
    modport slave  (input SCLK, input SS, input MOSI, output MISO);
endinterface

// File: rtl/spi_slave_regfile.sv
// Oversampled SPI mode-0 slave with four 8-bit registers, clocked only by PCLK.
// Frame: W, addr[1:0], 5 ignored bits, data[7:0]; MISO returns SYNC_PATTERN then the addressed register.
module spi_slave_regfile #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] SYNC_PATTERN = 8'hA5
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    spi_slave_regfile_if.slave  spi,
    output logic [31:0]         reg_q,
    output logic                wr_strobe,
    output logic [1:0]          wr_addr,
    output logic                frame_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] END   = 2'd2;

    localparam int             SW          = $clog2(SYNC_STAGES + 1);
    localparam logic [SW-1:0]  SETTLE_DONE = SW'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ss_d;
    logic [SW-1:0]          settle_cnt;
    logic                   armed;

    logic [1:0]  state;
    logic [4:0]  bit_cnt;
    logic [15:0] rx;
    logic [15:0] tx;
    logic        miso_q;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    // A frame already running when reset releases must not start a transfer:
    // only honour ss_fall once SS has been seen high through a refilled synchroniser.
    assign ss_fall   = ~ss_s & ss_d & armed;

    assign spi.MISO = miso_q & ~spi.SS;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sclk_sync  <= '0;
            ss_sync    <= '1;
            mosi_sync  <= '0;
            sclk_d     <= 1'b0;
            ss_d       <= 1'b1;
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            if (settle_cnt != SETTLE_DONE)
                settle_cnt <= settle_cnt + 1'b1;
            else if (ss_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            miso_q    <= 1'b0;
            reg_q     <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            miso_q    <= (state == SHIFT) ? tx[15] : 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        rx      <= '0;
                        tx      <= {SYNC_PATTERN, 8'h00};
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx <= {rx[14:0], mosi_s};
                        if (bit_cnt != 5'd17)
                            bit_cnt <= bit_cnt + 5'd1;
                        // Two falls have already shifted tx, so the data byte lands two places up
                        // and emerges on MISO exactly at frame bit 7.
                        if (bit_cnt == 5'd2)
                            tx[9:2] <= reg_q[{rx[0], mosi_s, 3'b000} +: 8];
                    end
                    if (sclk_fall)
                        tx <= {tx[14:0], 1'b0};
                    if (ss_rise)
                        state <= END;
                end
                END: begin
                    if (bit_cnt == 5'd16) begin
                        if (rx[15]) begin
                            reg_q[{rx[14:13], 3'b000} +: 8] <= rx[7:0];
                            wr_strobe <= 1'b1;
                            wr_addr   <= rx[14:13];
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: table of SPI frames with hand-computed results,
// plus hand-written sequences for idle SCLK activity and reset in the middle of a frame.
module tb_spi_slave_regfile;

    logic        PCLK;
    logic        PRESETn;
    logic [31:0] reg_q;
    logic        wr_strobe;
    logic [1:0]  wr_addr;
    logic        frame_err;

    spi_slave_regfile_if bus ();

    spi_slave_regfile #(
        .SYNC_STAGES  (2),
        .SYNC_PATTERN (8'hA5)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .spi       (bus.slave),
        .reg_q     (reg_q),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        int          half_hi;
        int          half_lo;
        int          gap;
        logic [15:0] exp_miso;
        logic [31:0] exp_reg;
        int          exp_strobes;
        int          exp_errs;
        logic [1:0]  exp_addr;
    } vec_t;

    vec_t        vecs [8];
    int          tests_run = 0;
    int          failures  = 0;
    int          strobe_cnt = 0;
    int          err_cnt    = 0;
    logic [1:0]  last_addr  = 2'd0;
    logic [15:0] miso_word;
    logic [15:0] mask;
    logic [31:0] prev_reg;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Count strobe/error cycles shortly after each edge; a stretched pulse counts twice.
    always @(posedge PCLK) begin
        #1;
        if (wr_strobe) begin
            strobe_cnt++;
            last_addr = wr_addr;
        end
        if (frame_err)
            err_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Plays one mode-0 frame as the master; reset_at >= 0 pulses PRESETn before that SCLK rise.
    task automatic applyStimulus(input logic [15:0] word, input int nbits, input int hi, input int lo,
                                 input int reset_at, output logic [15:0] miso_bits);
        miso_bits = '0;
        bus.SS    = 1'b0;
        bus.MOSI  = word[15];
        repeat (lo) @(negedge PCLK);
        for (int i = 0; i < nbits; i++) begin
            if (i == reset_at) begin
                PRESETn = 1'b0;
                repeat (2) @(negedge PCLK);
                PRESETn = 1'b1;
                repeat (lo) @(negedge PCLK);
            end
            if (i < 16)
                miso_bits[15-i] = bus.MISO;
            bus.SCLK = 1'b1;
            repeat (hi) @(negedge PCLK);
            bus.SCLK = 1'b0;
            if (i < 15)
                bus.MOSI = word[14-i];
            else
                bus.MOSI = 1'b0;
            repeat (lo) @(negedge PCLK);
        end
        bus.SS   = 1'b1;
        bus.MOSI = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'hC03C, 16, 8, 8, 8, 16'hA500, 32'h003C_0000, 1, 0, 2'd2};
        vecs[1] = '{16'h4000, 16, 8, 8, 8, 16'hA53C, 32'h003C_0000, 1, 0, 2'd2};
        vecs[2] = '{16'hC0FF, 16, 4, 4, 4, 16'hA53C, 32'h00FF_0000, 2, 0, 2'd2};
        vecs[3] = '{16'h4000, 16, 4, 4, 8, 16'hA5FF, 32'h00FF_0000, 2, 0, 2'd2};
        vecs[4] = '{16'hA055,  9, 8, 8, 8, 16'hA500, 32'h00FF_0000, 2, 1, 2'd2};
        vecs[5] = '{16'hA055, 17, 8, 8, 8, 16'hA500, 32'h00FF_0000, 2, 2, 2'd2};
        vecs[6] = '{16'hE011, 16, 8, 8, 8, 16'hA500, 32'h11FF_0000, 3, 2, 2'd3};
        vecs[7] = '{16'h6000, 16, 4, 4, 8, 16'hA511, 32'h11FF_0000, 3, 2, 2'd3};

        PRESETn  = 1'b0;
        bus.SS   = 1'b1;
        bus.SCLK = 1'b0;
        bus.MOSI = 1'b0;
        repeat (3) @(negedge PCLK);
        checkOutput("reset_reg_q", reg_q, 32'h0);
        checkOutput("reset_wr_strobe", {31'h0, wr_strobe}, 32'h0);
        checkOutput("reset_wr_addr", {30'h0, wr_addr}, 32'h0);
        checkOutput("reset_frame_err", {31'h0, frame_err}, 32'h0);
        checkOutput("reset_miso", {31'h0, bus.MISO}, 32'h0);
        PRESETn = 1'b1;
        repeat (10) @(negedge PCLK);

        prev_reg = 32'h0;
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].frame, vecs[v].nbits, vecs[v].half_hi, vecs[v].half_lo, -1, miso_word);
            if (vecs[v].nbits < 16)
                mask = 16'hFFFF << (16 - vecs[v].nbits);
            else
                mask = 16'hFFFF;
            checkOutput("miso_frame", {16'h0, miso_word & mask}, {16'h0, vecs[v].exp_miso & mask});
            repeat (3) @(negedge PCLK);
            checkOutput("miso_ss_high", {31'h0, bus.MISO}, 32'h0);
            checkOutput("reg_q_before_commit", reg_q, prev_reg);
            @(negedge PCLK);
            checkOutput("reg_q", reg_q, vecs[v].exp_reg);
            checkOutput("wr_strobe_count", strobe_cnt, vecs[v].exp_strobes);
            checkOutput("frame_err_count", err_cnt, vecs[v].exp_errs);
            checkOutput("wr_addr", {30'h0, last_addr}, {30'h0, vecs[v].exp_addr});
            prev_reg = vecs[v].exp_reg;
            repeat (vecs[v].gap - 4) @(negedge PCLK);
        end

        // SCLK toggling with SS high must not be treated as a frame.
        bus.MOSI = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.SCLK = 1'b1;
            repeat (4) @(negedge PCLK);
            bus.SCLK = 1'b0;
            repeat (4) @(negedge PCLK);
        end
        bus.MOSI = 1'b0;
        repeat (8) @(negedge PCLK);
        checkOutput("idle_sclk_reg_q", reg_q, 32'h11FF_0000);
        checkOutput("idle_sclk_strobes", strobe_cnt, 3);
        checkOutput("idle_sclk_errs", err_cnt, 2);
        checkOutput("idle_sclk_miso", {31'h0, bus.MISO}, 32'h0);

        // Reset after 10 bits of a write; the remainder of that frame must be ignored.
        applyStimulus(16'hE0AA, 16, 8, 8, 10, miso_word);
        checkOutput("reset_frame_miso", {16'h0, miso_word}, 32'h0000_A500);
        repeat (8) @(negedge PCLK);
        checkOutput("reset_frame_reg_q", reg_q, 32'h0);
        checkOutput("reset_frame_strobes", strobe_cnt, 3);
        checkOutput("reset_frame_errs", err_cnt, 2);

        applyStimulus(16'hA077, 16, 8, 8, -1, miso_word);
        checkOutput("post_reset_miso", {16'h0, miso_word}, 32'h0000_A500);
        repeat (8) @(negedge PCLK);
        checkOutput("post_reset_reg_q", reg_q, 32'h0000_7700);
        checkOutput("post_reset_strobes", strobe_cnt, 4);
        checkOutput("post_reset_wr_addr", {30'h0, last_addr}, 32'h1);
        checkOutput("post_reset_errs", err_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
